// File: rtl/uarch_pkg.sv
// rtl/uarch_pkg.sv - shared store-queue types and widths
package uarch_pkg;

  localparam int SQ_ENTRIES = 8;
  localparam int TAG_WIDTH  = 6;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic                 committed;
    logic [TAG_WIDTH-1:0] rob_id;
    mem_size_e            size;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      data;
  } sq_entry_t;

  function automatic logic misaligned(mem_size_e size, logic [1:0] off);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return off[0];
      MEM_W:   return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sq_lane_align.sv
// rtl/sq_lane_align.sv - place store data into D-cache byte lanes
module sq_lane_align import uarch_pkg::*; (
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] data,
  output logic [3:0]      be,
  output logic [XLEN-1:0] lane_data
);

  // Replicating the narrow value across lanes means the enables alone pick the target bytes.
  always_comb begin
    be        = 4'b0000;
    lane_data = data;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << off;
        lane_data = {4{data[7:0]}};
      end
      MEM_H: begin
        be        = 4'b0011 << off;
        lane_data = {2{data[15:0]}};
      end
      MEM_W: begin
        be        = 4'b1111;
        lane_data = data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order store queue between dispatch, store AGU, ROB and D-cache
module store_queue import uarch_pkg::*; #(
  parameter int SQ_ENTRIES = uarch_pkg::SQ_ENTRIES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_val,
  input  logic [TAG_WIDTH-1:0] alloc_rob_id,
  input  logic [1:0]           alloc_size,
  output logic                 alloc_rdy,
  input  logic                 exec_val,
  input  logic [TAG_WIDTH-1:0] exec_rob_id,
  input  logic [XLEN-1:0]      exec_addr,
  input  logic [XLEN-1:0]      exec_data,
  input  logic                 store_val,
  input  logic [TAG_WIDTH-1:0] store_id,
  output logic                 dc_req_val,
  output logic [XLEN-1:0]      dc_req_addr,
  output logic [XLEN-1:0]      dc_req_data,
  output logic [3:0]           dc_req_be,
  input  logic                 dc_req_rdy,
  output logic                 sq_empty
);

  localparam int PW = $clog2(SQ_ENTRIES);

  sq_entry_t q [SQ_ENTRIES];

  logic [PW:0]           head, commit_ptr, tail;
  logic [PW-1:0]         head_idx, commit_idx, tail_idx;
  logic                  full, alloc_fire, commit_fire, drain_fire;
  logic [SQ_ENTRIES-1:0] exec_hit;
  sq_entry_t             head_e;
  logic [3:0]            lane_be;
  logic [XLEN-1:0]       lane_data;

  assign head_idx   = head[PW-1:0];
  assign commit_idx = commit_ptr[PW-1:0];
  assign tail_idx   = tail[PW-1:0];

  assign full        = (head[PW] != tail[PW]) && (head_idx == tail_idx);
  assign sq_empty    = (head == tail);
  assign alloc_rdy   = !full;
  assign alloc_fire  = alloc_val && !full && !flush;
  assign commit_fire = store_val && q[commit_idx].valid;

  assign head_e      = q[head_idx];
  assign dc_req_val  = head_e.valid && head_e.committed;
  assign drain_fire  = dc_req_val && dc_req_rdy;

  always_comb begin
    exec_hit = '0;
    for (int i = 0; i < SQ_ENTRIES; i++)
      exec_hit[i] = q[i].valid && (q[i].rob_id == exec_rob_id);
  end

  sq_lane_align u_align (
    .size      (head_e.size),
    .off       (head_e.addr[1:0]),
    .data      (head_e.data),
    .be        (lane_be),
    .lane_data (lane_data)
  );

  assign dc_req_addr = dc_req_val ? {head_e.addr[XLEN-1:2], 2'b00} : '0;
  assign dc_req_data = dc_req_val ? lane_data : '0;
  assign dc_req_be   = dc_req_val ? lane_be : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SQ_ENTRIES; i++) q[i] <= '0;
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
    end else begin
      assert (!(alloc_val && full && !flush));
      if (exec_val && !flush) assert ($countones(exec_hit) == 1);
      if (store_val)
        assert (q[commit_idx].valid && q[commit_idx].ready &&
                !q[commit_idx].committed && (q[commit_idx].rob_id == store_id));
      if (dc_req_val) assert (!misaligned(head_e.size, head_e.addr[1:0]));

      if (drain_fire) begin
        q[head_idx].valid <= 1'b0;
        head              <= head + 1'b1;
      end

      if (commit_fire) begin
        q[commit_idx].committed <= 1'b1;
        commit_ptr              <= commit_ptr + 1'b1;
      end

      // The release in the flush cycle counts, so that entry survives and tail lands past it.
      if (flush) begin
        for (int i = 0; i < SQ_ENTRIES; i++)
          if (q[i].valid && !q[i].committed && !(commit_fire && (PW'(i) == commit_idx)))
            q[i].valid <= 1'b0;
        tail <= commit_fire ? commit_ptr + 1'b1 : commit_ptr;
      end else begin
        if (alloc_fire) begin
          q[tail_idx] <= '{valid: 1'b1, ready: 1'b0, committed: 1'b0, rob_id: alloc_rob_id,
                           size: mem_size_e'(alloc_size), addr: '0, data: '0};
          tail        <= tail + 1'b1;
        end
        if (exec_val)
          for (int i = 0; i < SQ_ENTRIES; i++)
            if (exec_hit[i]) begin
              q[i].addr  <= exec_addr;
              q[i].data  <= exec_data;
              q[i].ready <= 1'b1;
            end
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed scoreboard bench for store_queue
module tb_store_queue;
  import uarch_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic                 alloc_val, alloc_rdy;
  logic [TAG_WIDTH-1:0] alloc_rob_id;
  logic [1:0]           alloc_size;
  logic                 exec_val;
  logic [TAG_WIDTH-1:0] exec_rob_id;
  logic [XLEN-1:0]      exec_addr, exec_data;
  logic                 store_val;
  logic [TAG_WIDTH-1:0] store_id;
  logic                 dc_req_val, dc_req_rdy, sq_empty;
  logic [XLEN-1:0]      dc_req_addr, dc_req_data;
  logic [3:0]           dc_req_be;

  int passes = 0;
  int checks = 0;
  int fails  = 0;
  int drained = 0;
  int d0;

  logic [67:0] exp_by_tag [64];
  logic [1:0]  size_by_tag [64];
  logic [67:0] exp_q [$];

  always #5 clk = ~clk;

  store_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_val    (alloc_val),
    .alloc_rob_id (alloc_rob_id),
    .alloc_size   (alloc_size),
    .alloc_rdy    (alloc_rdy),
    .exec_val     (exec_val),
    .exec_rob_id  (exec_rob_id),
    .exec_addr    (exec_addr),
    .exec_data    (exec_data),
    .store_val    (store_val),
    .store_id     (store_id),
    .dc_req_val   (dc_req_val),
    .dc_req_addr  (dc_req_addr),
    .dc_req_data  (dc_req_data),
    .dc_req_be    (dc_req_be),
    .dc_req_rdy   (dc_req_rdy),
    .sq_empty     (sq_empty)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: {be, word address, lane data}, built lane by lane.
  function automatic logic [67:0] model(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] data);
    logic [3:0]  be;
    logic [31:0] d;
    int          off;
    off = int'(addr[1:0]);
    for (int k = 0; k < 4; k++) begin
      case (size)
        2'b00: begin
          be[k]      = (k == off);
          d[8*k +: 8] = data[7:0];
        end
        2'b01: begin
          be[k]      = (k == off) || (k == off + 1);
          d[8*k +: 8] = data[8*(k%2) +: 8];
        end
        default: begin
          be[k]      = 1'b1;
          d[8*k +: 8] = data[8*k +: 8];
        end
      endcase
    end
    return {be, addr[31:2], 2'b00, d};
  endfunction

  always @(negedge clk) begin
    if (rst && dc_req_val && dc_req_rdy) begin
      if (exp_q.size() == 0) check("sb_pending", 64'(exp_q.size()), 64'd1);
      else begin
        logic [67:0] e;
        e = exp_q.pop_front();
        check("req_be",   64'(dc_req_be),   64'(e[67:64]));
        check("req_addr", 64'(dc_req_addr), 64'(e[63:32]));
        check("req_data", 64'(dc_req_data), 64'(e[31:0]));
        drained++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int tag, input logic [1:0] size);
    alloc_val    = 1'b1;
    alloc_rob_id = TAG_WIDTH'(tag);
    alloc_size   = size;
    size_by_tag[tag] = size;
    step();
    alloc_val = 1'b0;
  endtask

  task automatic exec(input int tag, input logic [31:0] addr, input logic [31:0] data);
    exec_val    = 1'b1;
    exec_rob_id = TAG_WIDTH'(tag);
    exec_addr   = addr;
    exec_data   = data;
    exp_by_tag[tag] = model(size_by_tag[tag], addr, data);
    step();
    exec_val = 1'b0;
  endtask

  task automatic commit(input int tag);
    store_val = 1'b1;
    store_id  = TAG_WIDTH'(tag);
    exp_q.push_back(exp_by_tag[tag]);
    step();
    store_val = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 200 && !sq_empty; i++) step();
    check(name, 64'(sq_empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    alloc_val = 1'b0; alloc_rob_id = '0; alloc_size = 2'b00;
    exec_val = 1'b0; exec_rob_id = '0; exec_addr = '0; exec_data = '0;
    store_val = 1'b0; store_id = '0; dc_req_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alloc_rdy", 64'(alloc_rdy),   64'd1);
    check("rst_req_val",   64'(dc_req_val),  64'd0);
    check("rst_empty",     64'(sq_empty),    64'd1);
    check("rst_req_addr",  64'(dc_req_addr), 64'd0);
    check("rst_req_data",  64'(dc_req_data), 64'd0);
    check("rst_req_be",    64'(dc_req_be),   64'd0);
    rst = 1'b1;
    step();

    // Two stores released in order.
    alloc(3, 2'b10);
    alloc(4, 2'b10);
    exec(3, 32'h0000_0100, 32'h1111_1111);
    exec(4, 32'h0000_0104, 32'h2222_2222);
    commit(3);
    commit(4);
    check("t1_head_addr", 64'(dc_req_addr), 64'h100);
    dc_req_rdy = 1'b1;
    wait_empty("t1_empty");
    check("t1_drained", 64'(drained), 64'd2);
    dc_req_rdy = 1'b0;

    // Byte store at lane 3, then a 5-cycle cache stall.
    alloc(5, 2'b00);
    exec(5, 32'h0000_1003, 32'h0000_00AB);
    commit(5);
    check("sb_val",  64'(dc_req_val),  64'd1);
    check("sb_addr", 64'(dc_req_addr), 64'h1000);
    check("sb_be",   64'(dc_req_be),   64'b1000);
    check("sb_data", 64'(dc_req_data), 64'hABAB_ABAB);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_val",  64'(dc_req_val),  64'd1);
      check("stall_addr", 64'(dc_req_addr), 64'h1000);
      check("stall_data", 64'(dc_req_data), 64'hABAB_ABAB);
      check("stall_head", 64'(sq_empty),    64'd0);
    end
    dc_req_rdy = 1'b1;
    wait_empty("sb_empty");
    dc_req_rdy = 1'b0;

    // Fill to capacity, free one slot.
    for (int t = 10; t < 18; t++) alloc(t, 2'b10);
    check("full_rdy", 64'(alloc_rdy), 64'd0);
    for (int t = 10; t < 18; t++) exec(t, 32'h2000 + 32'(4 * (t - 10)), $urandom);
    commit(10);
    dc_req_rdy = 1'b1;
    @(negedge clk);
    check("full_same_cycle", 64'(alloc_rdy), 64'd0);
    step();
    dc_req_rdy = 1'b0;
    check("full_freed", 64'(alloc_rdy), 64'd1);
    for (int t = 11; t < 18; t++) commit(t);
    dc_req_rdy = 1'b1;
    wait_empty("full_empty");
    dc_req_rdy = 1'b0;

    // Flush with 2 of 5 committed.
    for (int t = 20; t < 25; t++) alloc(t, 2'b10);
    for (int t = 20; t < 25; t++) exec(t, 32'h3000 + 32'(4 * (t - 20)), $urandom);
    commit(20);
    commit(21);
    d0 = drained;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_nonempty", 64'(sq_empty),  64'd0);
    check("flush_rdy",      64'(alloc_rdy), 64'd1);
    dc_req_rdy = 1'b1;
    wait_empty("flush_empty");
    check("flush_drained", 64'(drained - d0), 64'd2);
    alloc(25, 2'b10);
    exec(25, 32'h0000_3100, 32'hCAFE_F00D);
    commit(25);
    wait_empty("post_flush_empty");
    check("post_flush_drained", 64'(drained - d0), 64'd3);

    // Pointer wrap with mixed sizes.
    d0 = drained;
    for (int i = 0; i < 20; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'(i % 3);
      a  = 32'h4000 + 32'(16 * i);
      if (sz == 2'b00) a = a + 32'(i % 4);
      else if (sz == 2'b01) a = a + 32'(2 * (i % 2));
      alloc(30 + i, sz);
      exec(30 + i, a, $urandom);
      commit(30 + i);
    end
    wait_empty("wrap_empty");
    check("wrap_drained", 64'(drained - d0), 64'd20);
    dc_req_rdy = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
